// File: rtl/life_step_engine.sv
// life_step_engine: 8x8 Game of Life (B3/S23) next-generation engine.
// Captures an initial board, then on each step evaluates one cell per clock
// into a shadow buffer and commits the whole generation in a single cycle.
// Optional feature macro: LIFE_TORUS_EN (defined: toroidal board edges;
// undefined: cells beyond the edge count as dead).
module life_step_engine #(
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [63:0]      board_in,
    input  logic             step,
    output logic [63:0]      board,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] generation
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  idx;
    logic [63:0] next_board;
    logic [3:0]  nbr_count;
    logic        cell_next;

    // Row/column coordinates of the three neighbour lines around idx
    // (index 0 = minus one, 1 = same, 2 = plus one) and whether each is on-board.
    logic [2:0]  nbr_rows [3];
    logic [2:0]  nbr_cols [3];
    logic [2:0]  row_ok;
    logic [2:0]  col_ok;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state logic: load wins over step in IDLE; requests are ignored while busy.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (step && !load) state_nxt = COMPUTE;
            COMPUTE: if (idx == 6'd63)  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: busy spans the whole computation including the commit cycle.
    always_comb begin
        busy = (state != IDLE);
    end

    // Neighbour coordinates for the cell being evaluated; edge policy set by LIFE_TORUS_EN.
    always_comb begin
        nbr_rows[1] = idx[5:3];
        nbr_cols[1] = idx[2:0];
        row_ok      = 3'b111;
        col_ok      = 3'b111;
`ifdef LIFE_TORUS_EN
        // 3-bit arithmetic wraps row 7 onto row 0 and column 7 onto column 0.
        nbr_rows[0] = idx[5:3] - 3'd1;
        nbr_rows[2] = idx[5:3] + 3'd1;
        nbr_cols[0] = idx[2:0] - 3'd1;
        nbr_cols[2] = idx[2:0] + 3'd1;
`else
        // The borrow/carry out of the 3-bit step marks a coordinate off the board.
        {row_ok[0], nbr_rows[0]} = {1'b1, idx[5:3]} - 4'd1;
        {row_ok[2], nbr_rows[2]} = {1'b0, idx[5:3]} + 4'd1;
        {col_ok[0], nbr_cols[0]} = {1'b1, idx[2:0]} - 4'd1;
        {col_ok[2], nbr_cols[2]} = {1'b0, idx[2:0]} + 4'd1;
        row_ok[2] = ~row_ok[2];
        col_ok[2] = ~col_ok[2];
`endif
    end

    // Neighbour count (0..8) and the B3/S23 rule for cell idx.
    always_comb begin
        nbr_count = 4'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!(i == 1 && j == 1) && row_ok[i] && col_ok[j]) begin
                    nbr_count = nbr_count + {3'b000, board[{nbr_rows[i], nbr_cols[j]}]};
                end
            end
        end
        cell_next = (nbr_count == 4'd3) || (board[idx] && (nbr_count == 4'd2));
    end

    // Datapath: board capture, per-cell shadow writes, whole-board commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board      <= 64'h0;
            next_board <= 64'h0;
            idx        <= 6'd0;
            done       <= 1'b0;
            generation <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        board      <= board_in;
                        generation <= '0;
                    end else if (step) begin
                        idx <= 6'd0;
                    end
                end
                COMPUTE: begin
                    next_board[idx] <= cell_next;
                    idx             <= idx + 6'd1;
                end
                COMMIT: begin
                    board      <= next_board;
                    done       <= 1'b1;
                    generation <= generation + GEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_step_engine.sv
// Self-checking bench for life_step_engine: directed Life patterns plus random
// boards compared against a cell-by-cell reference model of rule B3/S23.
// Honours LIFE_TORUS_EN the same way as the design.
module tb_life_step_engine;

    localparam logic [63:0] BLINKER_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINKER_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK     = 64'h0000_0018_1800_0000;
    localparam logic [63:0] CORNERS   = 64'h0100_0000_0000_0081;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [63:0] board_in;
    logic        step;
    logic [63:0] board;
    logic        busy;
    logic        done;
    logic [15:0] generation;

    int          checks;
    int          failures;
    int          done_cnt;
    logic [63:0] ref_board;
    int          ref_gen;

    life_step_engine #(.GEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .board_in   (board_in),
        .step       (step),
        .board      (board),
        .busy       (busy),
        .done       (done),
        .generation (generation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: count the live neighbours of every cell on an integer grid.
    function automatic logic [63:0] model_step(input logic [63:0] b);
        logic [63:0] n;
        int cnt;
        int rr;
        int cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_TORUS_EN
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                            cnt += int'(b[rr*8 + cc]);
`else
                            if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                                cnt += int'(b[rr*8 + cc]);
`endif
                        end
                    end
                end
                n[r*8 + c] = (cnt == 3) || (b[r*8 + c] && cnt == 2);
            end
        end
        return n;
    endfunction

    task automatic do_load(input string tag, input logic [63:0] b);
        @(negedge clk);
        load     = 1'b1;
        board_in = b;
        @(negedge clk);
        load     = 1'b0;
        board_in = 64'h0;
        check({tag, "_load_board"}, board, b);
        check({tag, "_load_gen"}, 64'(generation), 64'd0);
        ref_board = b;
        ref_gen   = 0;
    endtask

    // One generation; optionally fire load+step with an all-ones board mid-compute.
    task automatic run_step(input string tag, input bit perturb);
        logic [63:0] exp;
        int          cyc;
        int          d0;
        exp = model_step(ref_board);
        d0  = done_cnt;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check({tag, "_busy_hi"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!done && cyc < 200) begin
            if (perturb && cyc == 10) begin
                load     = 1'b1;
                step     = 1'b1;
                board_in = '1;
            end else if (perturb && cyc == 11) begin
                load     = 1'b0;
                step     = 1'b0;
                board_in = 64'h0;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd65);
        check({tag, "_board"}, board, exp);
        check({tag, "_gen"}, 64'(generation), 64'((ref_gen + 1) & 16'hFFFF));
        check({tag, "_busy_lo"}, 64'(busy), 64'd0);
        ref_board = exp;
        ref_gen++;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        ref_board = '0;
        ref_gen   = 0;
        rst_n     = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        board_in  = 64'h0;

        #1;
        check("rst_board", board, 64'h0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_gen", 64'(generation), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Blinker oscillates with period 2.
        do_load("blink", BLINKER_H);
        run_step("blink1", 1'b0);
        check("blink1_const", board, BLINKER_V);
        run_step("blink2", 1'b0);
        check("blink2_const", board, BLINKER_H);
        check("blink2_gen_const", 64'(generation), 64'd2);

        // Block is a still life.
        do_load("block", BLOCK);
        for (int k = 0; k < 3; k++) begin
            run_step("block", 1'b0);
            check("block_const", board, BLOCK);
        end
        check("block_gen_const", 64'(generation), 64'd3);

        // Corner cells: edge policy decides the outcome.
        do_load("corner", CORNERS);
        run_step("corner", 1'b0);
`ifdef LIFE_TORUS_EN
        check("corner_const", board, 64'h8100_0000_0000_0081);
`else
        check("corner_const", board, 64'h0);
`endif

        // Requests during computation are ignored.
        do_load("rej", BLINKER_H);
        run_step("rej", 1'b1);
        check("rej_const", board, BLINKER_V);

        // Load and step together in IDLE: load wins, step dropped.
        d0 = done_cnt;
        @(negedge clk);
        load     = 1'b1;
        step     = 1'b1;
        board_in = BLINKER_H;
        @(negedge clk);
        load     = 1'b0;
        step     = 1'b0;
        board_in = 64'h0;
        check("coll_board", board, BLINKER_H);
        check("coll_busy", 64'(busy), 64'd0);
        repeat (70) @(negedge clk);
        check("coll_busy_late", 64'(busy), 64'd0);
        check("coll_no_done", 64'(done_cnt - d0), 64'd0);
        check("coll_board_late", board, BLINKER_H);
        ref_board = BLINKER_H;
        ref_gen   = 0;

        // Random boards, dense and sparse, two generations each.
        for (int k = 0; k < 6; k++) begin
            logic [63:0] rb;
            rb = {$urandom, $urandom};
            if (k[0]) rb = rb & {$urandom, $urandom};
            do_load("rand", rb);
            run_step("rand_a", 1'b0);
            run_step("rand_b", 1'b0);
        end

        // Reset during COMPUTE aborts without a done pulse.
        do_load("abort", BLINKER_H);
        d0 = done_cnt;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_busy_pre", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_board", board, 64'h0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_gen", 64'(generation), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        do_load("post", BLOCK);
        run_step("post", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_step_engine.md
# life_step_engine

Next-generation engine for the 8x8 Game of Life board. Sits directly downstream of the board memory: it captures the 64-bit initial board the memory produces, then advances it one generation per `step` request under rule B3/S23. It evaluates one cell per clock into a shadow buffer and commits the whole board at once, so the `board` output never shows a half-updated generation.

## Interface
Parameters:
- `GEN_W`, default 16: width of the generation counter.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `load`  input  1  capture `board_in` (honoured only in IDLE).
- `board_in`  input  64  initial board from memory; bit i = row i[5:3], column i[2:0].
- `step`  input  1  request one generation (honoured only in IDLE).
- `board`  output  64  current committed generation.
- `busy`  output  1  high in COMPUTE and COMMIT.
- `done`  output  1  one-cycle pulse when a generation commits.
- `generation`  output  GEN_W  count of committed generations since the last load or reset.

## Operation
- States are IDLE, COMPUTE and COMMIT.
- **IDLE, `load`=1:**
  - `board` <= `board_in`.
  - `generation` <= 0.
  - State stays IDLE.
  - `load` has priority: a simultaneous `step` is dropped, not queued.
- **IDLE, `step`=1, `load`=0:**
  - Cell index `idx` <= 0.
  - State goes to COMPUTE.
- **COMPUTE:** each cycle evaluates cell `idx` from `board`, which is frozen during the computation.
  - Count the 8 neighbours into a 4-bit sum, range 0..8.
  - Next cell state = (count==3) | (`board[idx]` & count==2).
  - Write the result into shadow `next[idx]`.
  - `idx` increments. At `idx`==63, go to COMMIT.
- **COMMIT:**
  - `board` <= `next`.
  - `done` = 1 for this cycle.
  - `generation` <= `generation`+1, wrapping modulo 2^GEN_W.
  - Then return to IDLE.
- Neighbour addressing: row and column are each ±1, computed with 3-bit modulo arithmetic. Edge handling is set by the Configuration macro.
- Inputs arriving while busy:
  - `load` and `step` are ignored entirely and not latched.
  - `board_in` changes have no effect.

## Timing
- Reset (async assert, sync release):
  - `board` = 64'h0, `busy` = 0, `done` = 0, `generation` = 0.
  - State = IDLE, `idx` = 0, `next` = 0.
- Load latency: `board` updates at the first edge where `load`=1 in IDLE. The value is visible the following cycle.
- Step latency, with `step` sampled at edge T0:
  - `busy` goes high after T0.
  - COMPUTE covers edges T1..T64, one cell each.
  - COMMIT is the cycle after T64: `done`=1 and the new `board` appear after edge T65.
  - `busy` falls after T65.
  - A new `step` is accepted at T66 at the earliest.
  - Throughput: 66 cycles per generation.
- `done` is high for exactly one cycle, coincident with the first cycle the new `board` is valid.
- Reset asserted mid-COMPUTE or at COMMIT aborts immediately. The partial `next` is discarded and no `done` is issued.

## Configuration
- `LIFE_TORUS_EN` defined: the board wraps toroidally. Row 7 neighbours row 0 and column 7 neighbours column 0, via 3-bit wrap.
- `LIFE_TORUS_EN` undefined: coordinates outside 0..7 count as dead cells. Out-of-range detection uses the carry and borrow of the ±1 arithmetic.

## Test plan
- Blinker: load 64'h0000_0000_1C00_0000, step -> `done` after 65 cycles, `board`=64'h0000_0008_0808_0000, `generation`=1. A second step returns the original board with `generation`=2.
- Still life: load block 64'h0000_0018_1800_0000, step ×3 -> board unchanged each time, `generation`=3.
- Corner wrap: load 64'h0100_0000_0000_0081 (cells 0, 7, 56), step.
  - With `LIFE_TORUS_EN`: `board`=64'h8100_0000_0000_0081.
  - Without it: `board`=64'h0.
- Busy rejection: step, then pulse `load` with 64'hFFFF… and `step` at cycle 10 -> result identical to the unperturbed run, exactly one `done`.
- Load/step collision: in IDLE, assert `load`=1 and `step`=1 together with board_in=blinker -> board = blinker, `busy` stays 0, no `done`.
- Reset abort: assert `rst_n`=0 at cycle 30 of COMPUTE -> all outputs take reset values immediately, no `done` pulse; after release, IDLE accepts `load`.
